dmem_ctrl: RTL



---
 rtl/dmem_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port data memory slave for the processor data port.
//
// Accepts one load or store at a time and adds WAIT_STATES cycles between acceptance and
// acknowledge. Stores commit, and load data is registered, on the edge that enters the
// response cycle. The memory array is not reset. A request that reset catches before it
// reaches the response cycle is dropped without an ack.
//
// Optional feature: define DMEM_CTRL_ERR_EN to add err_o. err_o flags out-of-range or
// misaligned requests in the ack cycle. With err_o enabled, misaligned stores are dropped
// and misaligned loads return zero.
//
// Ports:
//   clk_i    : clock, rising edge
//   arst_i   : asynchronous active-high reset
//   req_i    : request, held by the master until ack_o
//   we_i     : 1 = store, 0 = load
//   addr_i   : byte address
//   wdata_i  : store data
//   rdata_o  : load data, valid with ack_o for loads, held until the next load completes
//   ack_o    : one-cycle completion pulse
//   err_o    : (DMEM_CTRL_ERR_EN only) error flag, valid with ack_o

`timescale 1ns / 1ps

module dmem_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ack_o
`ifdef DMEM_CTRL_ERR_EN
  ,
  output logic                  err_o
`endif
);

  localparam int unsigned OFF  = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDXW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    ack_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    accept;
  logic                    commit;
  logic                    cur_we;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [DATA_WIDTH-1:0]   cur_wdata;
  logic                    in_range;
  logic                    ok;
  logic [IDXW-1:0]         idx;

`ifdef DMEM_CTRL_ERR_EN
  localparam logic [ADDR_WIDTH-1:0] LowMask = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);
  logic misaligned;
  logic err_q;
`endif

  // With zero wait states the request commits on its own acceptance edge, so the live
  // inputs are used in IDLE; every other commit uses the latched request.
  always_comb begin
    accept    = (state_q == StIdle) && req_i;
    commit    = !arst_i && ((accept && (WAIT_STATES == 0)) ||
                            ((state_q == StWait) && (cnt_q == 4'd1)));
    cur_we    = (state_q == StIdle) ? we_i    : we_q;
    cur_addr  = (state_q == StIdle) ? addr_i  : addr_q;
    cur_wdata = (state_q == StIdle) ? wdata_i : wdata_q;
    in_range  = ((cur_addr >> (OFF + IDXW)) == '0);
    idx       = cur_addr[OFF +: IDXW];
`ifdef DMEM_CTRL_ERR_EN
    misaligned = |(cur_addr & LowMask);
    ok         = in_range && !misaligned;
`else
    ok         = in_range;
`endif
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
`ifdef DMEM_CTRL_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ack_q <= commit;
`ifdef DMEM_CTRL_ERR_EN
      err_q <= commit && !ok;
`endif
      if (commit && !cur_we) begin
        rdata_q <= ok ? mem_q[idx] : '0;
      end
      unique case (state_q)
        StIdle: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            cnt_q   <= 4'(WAIT_STATES);
            state_q <= (WAIT_STATES == 0) ? StResp : StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          // The held req_i belongs to the transaction being acknowledged.
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage has no reset; a reset before the commit edge leaves the word untouched.
  always_ff @(posedge clk_i) begin
    if (commit && cur_we && ok) begin
      mem_q[idx] <= cur_wdata;
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
`ifdef DMEM_CTRL_ERR_EN
  assign err_o   = err_q;
`endif

endmodule
